// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a single-byte holding register.
// The line is synchronised into the clk domain and sampled at bit centres.
// Each good byte is offered through a valid/ack handshake. A stop bit that
// samples 0 gives a one-cycle frame_err pulse. A byte that completes while
// the holding register is still full is dropped and sets the sticky overrun.
module uart_receiver #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CPB   = CLK_HZ / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             rxd_meta_q;
    logic             rxd_s_q;
    logic             done_q;
    logic             ferr_pend_q;
    logic             busy_q;
    logic [7:0]       data_q,  data_d;
    logic             valid_q, valid_d;
    logic             ovr_q,   ovr_d;
    logic             frame_err_q;

    // Two-flop synchroniser; both flops reset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // Receive FSM: start-bit qualification, centre sampling, stop check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            ferr_pend_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            ferr_pend_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rxd_s_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        if (rxd_s_q) begin
                            // Line went back high before mid-start: a glitch.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_idx_q <= '0;
                            state_q   <= S_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q     <= '0;
                        shift_q   <= {rxd_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q <= '0;
                        if (rxd_s_q) begin
                            // Leave at mid-stop so a back-to-back start edge is seen.
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_pend_q <= 1'b1;
                            state_q     <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low line (break) must not look like a new start bit.
                    cnt_q <= '0;
                    if (rxd_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Holding register: ack frees the slot, and a delivery may reuse it in the same cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (done_q) begin
            if (!valid_q || ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                ovr_d   = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Register the holding outputs; frame_err lines up with the would-be valid rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            frame_err_q <= ferr_pend_q;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign overrun   = ovr_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at CPB=16, HALF=8.
// The stimulus side pushes the expected event for each frame into a queue.
// A separate monitor pops that queue whenever the DUT shows an event.
module tb_uart_receiver;
    localparam int CPB  = 16;
    localparam int HALF = 8;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;
    localparam int K_DATA = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] b;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    // Reference model of the holding register: occupied flag, stored byte, sticky overrun.
    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;
    logic [7:0] m_data  = 8'h00;

    uart_receiver #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .ack       (ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_event(input int kind, input logic [7:0] b);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d data=%02h at cyc %0d, want no event", kind, b, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.b !== b || cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
                n_bad++;
                $display("FAIL event: got kind=%0d data=%02h cyc=%0d, want kind=%0d data=%02h cyc=%0d",
                         kind, b, cyc, e.kind, e.b, e.cyc);
            end
        end
    endtask

    // Expected outcome of one frame, from the receive rules, given the ack plan.
    task automatic model_frame(input logic [7:0] b, input logic stop, input int t0, input int ack_off);
        exp_t e;
        e.cyc  = t0 + LAT;
        e.b    = 8'h00;
        e.kind = K_FERR;
        if (ack_off == LAT - 1 && m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        if (!stop) begin
            exp_q.push_back(e);
        end else if (!m_valid) begin
            e.kind = K_DATA;
            e.b    = b;
            exp_q.push_back(e);
            m_valid = 1'b1;
            m_data  = b;
        end else begin
            if (!m_ovr) begin
                e.kind = K_OVR;
                e.b    = m_data;
                exp_q.push_back(e);
            end
            m_ovr = 1'b1;
        end
        if (ack_off == LAT + 1 && m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame from a negedge; optional one-cycle ack at t0+ack_off.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_off);
        int t0;
        t0 = cyc + 1;
        model_frame(b, stop, t0, ack_off);
        rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(CPB);
        end
        rxd = stop;
        for (int k = 0; k < CPB; k++) begin
            ack = (ack_off != 0) && (cyc == t0 + ack_off);
            if (ack_off == LAT + 1 && cyc == t0 + LAT + 2)
                check("ack_after_valid", valid, 0);
            @(negedge clk);
        end
        ack = 1'b0;
    endtask

    task automatic do_ack(input string name);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        check({name, "_valid"}, valid, 0);
        check({name, "_overrun"}, overrun, 0);
    endtask

    // Monitor: each DUT-visible event is matched against the head of the queue.
    initial begin : monitor
        logic       v_prev;
        logic       o_prev;
        logic [7:0] d_prev;
        v_prev = 1'b0;
        o_prev = 1'b0;
        d_prev = 8'h00;
        forever begin
            @(negedge clk);
            if (frame_err) check_event(K_FERR, 8'h00);
            if (valid && (!v_prev || data != d_prev)) check_event(K_DATA, data);
            if (overrun && !o_prev) check_event(K_OVR, data);
            v_prev = valid;
            o_prev = overrun;
            d_prev = data;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] rb;
        logic       rstop;
        int         mode;
        logic [7:0] pb;

        rst = 1'b0;
        rxd = 1'b1;
        ack = 1'b0;
        idle(3);
        check("reset_data", data, 8'h00);
        check("reset_valid", valid, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        rst = 1'b1;
        idle(4);

        // Clean byte, then consume it.
        send_frame(8'h55, 1'b1, 0);
        idle(2);
        check("t55_valid", valid, 1);
        check("t55_data", data, 8'h55);
        do_ack("t55_ack");

        // Short low glitch must be rejected at the start-bit centre.
        rxd = 1'b0;
        idle(4);
        check("glitch_busy_hi", busy, 1);
        rxd = 1'b1;
        idle(HALF + 3);
        check("glitch_busy_lo", busy, 0);
        check("glitch_valid", valid, 0);

        // Bad stop bit followed by a break, then a normal byte.
        send_frame(8'hA5, 1'b0, 0);
        idle(40);
        check("break_busy", busy, 1);
        check("break_valid", valid, 0);
        rxd = 1'b1;
        idle(10);
        check("break_busy_lo", busy, 0);
        send_frame(8'h3C, 1'b1, 0);
        idle(2);
        check("after_break_data", data, 8'h3C);
        do_ack("after_break_ack");

        // Overrun: second byte arrives while the first is unread.
        send_frame(8'h12, 1'b1, 0);
        idle(4);
        send_frame(8'h34, 1'b1, 0);
        idle(2);
        check("ovr_data", data, 8'h12);
        check("ovr_flag", overrun, 1);
        check("ovr_valid", valid, 1);
        do_ack("ovr_ack");

        // Back-to-back frames, each acked once valid is seen.
        send_frame(8'h00, 1'b1, LAT + 1);
        send_frame(8'hFF, 1'b1, LAT + 1);
        idle(2);
        check("b2b_overrun", overrun, 0);
        check("b2b_valid", valid, 0);

        // Back-to-back with ack landing on the second delivery cycle.
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, LAT - 1);
        idle(2);
        check("coinc_data", data, 8'hFF);
        check("coinc_valid", valid, 1);
        check("coinc_overrun", overrun, 0);

        // Asynchronous reset in the middle of data bit 4.
        pb = 8'h5A;
        rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = pb[i];
            idle(CPB);
        end
        rxd = pb[4];
        idle(CPB / 2);
        #2 rst = 1'b0;
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_valid", valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_frame_err", frame_err, 0);
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        rxd = 1'b1;
        idle(4);
        rst = 1'b1;
        idle(4);
        send_frame(8'hC3, 1'b1, 0);
        idle(2);
        check("post_rst_data", data, 8'hC3);
        do_ack("post_rst_ack");

        // Randomised frames, stop bits and consumer behaviour.
        for (int n = 0; n < 14; n++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 4) != 0);
            mode  = int'($urandom_range(0, 2));
            send_frame(rb, rstop, (mode == 2) ? LAT + 1 : 0);
            rxd = 1'b1;
            idle(int'($urandom_range(4, 30)));
            if (mode == 1) do_ack("rnd_ack");
        end

        idle(200);
        check("queue_drained", exp_q.size(), 0);
        check("final_valid", valid, m_valid);
        check("final_overrun", overrun, m_ovr);
        if (m_valid) check("final_data", data, m_data);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
